// File: rtl/hue_fade_controller.sv
// Three-channel PWM colour-wheel fader: step timer, phase scheduler, duty registers, PWM.
// Define LED_ACTIVE_LOW_EN for current-sinking LEDs (outputs inverted, reset high).
module hue_fade_controller #(
    parameter int INC_DEC_INTERVAL = 12000,
    parameter int INC_DEC_MAX      = 200,
    parameter int PWM_INTERVAL     = 1200,
    parameter int INC_DEC_VAL      = PWM_INTERVAL / INC_DEC_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic [2:0] phase,
    output logic       phase_tick
);

    localparam int TW = (INC_DEC_INTERVAL > 1) ? $clog2(INC_DEC_INTERVAL) : 1;
    localparam int SW = (INC_DEC_MAX > 1) ? $clog2(INC_DEC_MAX) : 1;
    localparam int PW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    localparam int DW = $clog2(PWM_INTERVAL + 1);

    localparam logic [TW-1:0] T_LAST = TW'(INC_DEC_INTERVAL - 1);
    localparam logic [SW-1:0] S_LAST = SW'(INC_DEC_MAX - 1);
    localparam logic [PW-1:0] P_LAST = PW'(PWM_INTERVAL - 1);
    localparam logic [DW-1:0] D_MAX  = DW'(PWM_INTERVAL);
    localparam logic [DW:0]   D_STEP = (DW+1)'(INC_DEC_VAL);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic LED_POL = 1'b1;
`else
    localparam logic LED_POL = 1'b0;
`endif

    typedef enum logic [1:0] {
        FADE_INC = 2'b00,
        FADE_DEC = 2'b01,
        FADE_ON  = 2'b10,
        FADE_OFF = 2'b11
    } fade_e;

    // Packed {R,G,B} fade codes for a phase.
    function automatic logic [5:0] phase_codes(input logic [2:0] ph);
        logic [5:0] c;
        case (ph)
            3'd0:    c = {FADE_ON,  FADE_INC, FADE_OFF};
            3'd1:    c = {FADE_DEC, FADE_ON,  FADE_OFF};
            3'd2:    c = {FADE_OFF, FADE_ON,  FADE_INC};
            3'd3:    c = {FADE_OFF, FADE_DEC, FADE_ON};
            3'd4:    c = {FADE_INC, FADE_OFF, FADE_ON};
            3'd5:    c = {FADE_ON,  FADE_OFF, FADE_DEC};
            default: c = {FADE_OFF, FADE_OFF, FADE_OFF};
        endcase
        return c;
    endfunction

    function automatic logic [DW-1:0] next_duty(
        input fade_e         c,
        input logic [DW-1:0] d
    );
        logic [DW:0]   sum;
        logic [DW-1:0] n;
        sum = {1'b0, d} + D_STEP;
        case (c)
            FADE_INC: n = (sum > {1'b0, D_MAX}) ? D_MAX : sum[DW-1:0];
            FADE_DEC: n = ({1'b0, d} < D_STEP) ? '0 : d - D_STEP[DW-1:0];
            FADE_ON:  n = D_MAX;
            default:  n = '0;
        endcase
        return n;
    endfunction

    logic [TW-1:0] timer_q, timer_d;
    logic [SW-1:0] scnt_q,  scnt_d;
    logic [2:0]    phase_q, phase_d;
    logic          tick_q,  tick_d;
    logic [PW-1:0] pwm_q,   pwm_d;
    logic [2:0]    led_q,   led_d;
    logic [DW-1:0] duty_q [3];
    logic [DW-1:0] duty_d [3];
    logic [5:0]    codes;
    logic          step;
    logic          wrap;

    assign step  = enable && (timer_q == T_LAST);
    assign wrap  = step && (scnt_q == S_LAST);
    assign codes = phase_codes(phase_q);

    always_comb begin
        timer_d = timer_q;
        scnt_d  = scnt_q;
        phase_d = phase_q;
        tick_d  = wrap;
        pwm_d   = (pwm_q == P_LAST) ? '0 : pwm_q + PW'(1);
        if (enable) begin
            timer_d = (timer_q == T_LAST) ? '0 : timer_q + TW'(1);
        end
        if (step) begin
            scnt_d = (scnt_q == S_LAST) ? '0 : scnt_q + SW'(1);
        end
        if (wrap) begin
            phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
        end
        // Index 2 = red, 1 = green, 0 = blue, matching the code packing.
        for (int i = 0; i < 3; i++) begin
            duty_d[i] = duty_q[i];
            if (step) begin
                duty_d[i] = next_duty(fade_e'(codes[2*i +: 2]), duty_q[i]);
            end
            led_d[i] = (DW'(pwm_q) < duty_q[i]) ^ LED_POL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            scnt_q    <= '0;
            phase_q   <= 3'd0;
            tick_q    <= 1'b0;
            pwm_q     <= '0;
            led_q     <= {3{LED_POL}};
            duty_q[2] <= D_MAX;
            duty_q[1] <= '0;
            duty_q[0] <= '0;
        end else begin
            timer_q <= timer_d;
            scnt_q  <= scnt_d;
            phase_q <= phase_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
            led_q   <= led_d;
            for (int i = 0; i < 3; i++) begin
                duty_q[i] <= duty_d[i];
            end
        end
    end

    assign red        = led_q[2];
    assign green      = led_q[1];
    assign blue       = led_q[0];
    assign phase      = phase_q;
    assign phase_tick = tick_q;

endmodule

// File: tb/tb_hue_fade_controller.sv
// Directed bench for hue_fade_controller with a 4/5/10 timing configuration.
// Output expectations flip automatically when LED_ACTIVE_LOW_EN is defined.
module tb_hue_fade_controller;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       red, green, blue;
    logic [2:0] phase;
    logic       phase_tick;

    int n_cmp = 0;
    int n_bad = 0;
    int n = 0;

    hue_fade_controller #(
        .INC_DEC_INTERVAL(4),
        .INC_DEC_MAX     (5),
        .PWM_INTERVAL    (10),
        .INC_DEC_VAL     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .phase     (phase),
        .phase_tick(phase_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset(input logic en);
        rst = 1'b1;
        enable = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        enable = en;
        n = 0;
    endtask

    task automatic test_reset();
        logic [2:0] leds;
        int bad;
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        leds = {red, green, blue};
        n_cmp++;
        if (leds !== {3{POL}}) begin
            n_bad++;
            $display("FAIL reset_leds got %b want %b", leds, {3{POL}});
        end
        n_cmp++;
        if (phase !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_phase got %0d want 0", phase);
        end
        n_cmp++;
        if (phase_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_tick got %b want 0", phase_tick);
        end
        rst = 1'b0;
        enable = 1'b1;
        n = 0;
        tick();
        leds = {red, green, blue};
        n_cmp++;
        if (leds !== {~POL, POL, POL}) begin
            n_bad++;
            $display("FAIL release_leds got %b want %b", leds, {~POL, POL, POL});
        end
        // Green duty reaches 4 at edge 8, first compare hit is edge 11.
        bad = 0;
        for (int i = 2; i <= 10; i++) begin
            tick();
            if (green !== POL || red !== ~POL || blue !== POL) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL early_leds bad_cycles %0d want 0", bad);
        end
        tick();
        n_cmp++;
        if (green !== ~POL) begin
            n_bad++;
            $display("FAIL green_first_high got %b want %b", green, ~POL);
        end
    endtask

    task automatic test_phase_advance();
        do_reset(1'b1);
        repeat (19) tick();
        n_cmp++;
        if (phase !== 3'd0 || phase_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_adv got ph=%0d tk=%b want 0 0", phase, phase_tick);
        end
        tick();
        n_cmp++;
        if (phase !== 3'd1 || phase_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL adv got ph=%0d tk=%b want 1 1", phase, phase_tick);
        end
        tick();
        n_cmp++;
        if (phase !== 3'd1 || phase_tick !== 1'b0 || green !== ~POL) begin
            n_bad++;
            $display("FAIL post_adv got ph=%0d tk=%b g=%b want 1 0 %b",
                     phase, phase_tick, green, ~POL);
        end
        // Red drops to 8 at edge 24; pwm 7 still lit, pwm 8 not.
        repeat (7) tick();
        n_cmp++;
        if (red !== ~POL) begin
            n_bad++;
            $display("FAIL red_e28 got %b want %b", red, ~POL);
        end
        tick();
        n_cmp++;
        if (red !== POL) begin
            n_bad++;
            $display("FAIL red_e29 got %b want %b", red, POL);
        end
    endtask

    task automatic test_full_cycle();
        logic [2:0] seq [6];
        logic [2:0] want [6];
        int ticks;
        int bad;
        want = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        ticks = 0;
        do_reset(1'b1);
        for (int i = 0; i < 120; i++) begin
            tick();
            if (phase_tick === 1'b1) begin
                if (ticks < 6) seq[ticks] = phase;
                ticks++;
            end
        end
        n_cmp++;
        if (ticks != 6) begin
            n_bad++;
            $display("FAIL tick_count got %0d want 6", ticks);
        end
        for (int i = 0; i < 6; i++) begin
            if (i < ticks) begin
                n_cmp++;
                if (seq[i] !== want[i]) begin
                    n_bad++;
                    $display("FAIL phase_seq[%0d] got %0d want %0d",
                             i, seq[i], want[i]);
                end
            end
        end
        n_cmp++;
        if (phase !== 3'd0) begin
            n_bad++;
            $display("FAIL wrap_phase got %0d want 0", phase);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (red !== ~POL || green !== POL || blue !== POL) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL wrap_duties bad_cycles %0d want 0", bad);
        end
    endtask

    task automatic test_pwm();
        int bad_g;
        int bad_rb;
        int highs;
        logic exp_g;
        bad_g = 0;
        bad_rb = 0;
        highs = 0;
        do_reset(1'b1);
        repeat (8) tick();
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_g = (((n - 1) % 10) < 4) ^ POL;
            if (green !== exp_g) bad_g++;
            if (green === ~POL) highs++;
            if (red !== ~POL || blue !== POL) bad_rb++;
        end
        n_cmp++;
        if (bad_g != 0) begin
            n_bad++;
            $display("FAIL pwm_align bad_cycles %0d want 0", bad_g);
        end
        n_cmp++;
        if (highs != 8) begin
            n_bad++;
            $display("FAIL pwm_duty4 got %0d want 8", highs);
        end
        n_cmp++;
        if (bad_rb != 0) begin
            n_bad++;
            $display("FAIL pwm_red_blue bad_cycles %0d want 0", bad_rb);
        end
    endtask

    task automatic test_pause();
        int bad;
        int highs;
        bad = 0;
        highs = 0;
        do_reset(1'b1);
        repeat (14) tick();
        enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (phase !== 3'd0 || phase_tick !== 1'b0) bad++;
            if (green === ~POL) highs++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL pause_frozen bad_cycles %0d want 0", bad);
        end
        n_cmp++;
        if (highs != 30) begin
            n_bad++;
            $display("FAIL pause_duty6 got %0d want 30", highs);
        end
        enable = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (phase !== 3'd0) begin
            n_bad++;
            $display("FAIL resume_e69 got %0d want 0", phase);
        end
        tick();
        n_cmp++;
        if (phase !== 3'd1 || phase_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL resume_e70 got ph=%0d tk=%b want 1 1",
                     phase, phase_tick);
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] leds;
        do_reset(1'b1);
        repeat (62) tick();
        n_cmp++;
        if (phase !== 3'd3 || blue !== ~POL) begin
            n_bad++;
            $display("FAIL ph3 got ph=%0d b=%b want 3 %b", phase, blue, ~POL);
        end
        rst = 1'b1;
        tick();
        leds = {red, green, blue};
        n_cmp++;
        if (phase !== 3'd0 || phase_tick !== 1'b0 || leds !== {3{POL}}) begin
            n_bad++;
            $display("FAIL midrst got ph=%0d tk=%b leds=%b want 0 0 %b",
                     phase, phase_tick, leds, {3{POL}});
        end
        rst = 1'b0;
        tick();
        leds = {red, green, blue};
        n_cmp++;
        if (leds !== {~POL, POL, POL}) begin
            n_bad++;
            $display("FAIL midrst_release got %b want %b", leds, {~POL, POL, POL});
        end
        repeat (18) tick();
        n_cmp++;
        if (phase !== 3'd0) begin
            n_bad++;
            $display("FAIL midrst_e82 got %0d want 0", phase);
        end
        tick();
        n_cmp++;
        if (phase !== 3'd1 || phase_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_e83 got ph=%0d tk=%b want 1 1",
                     phase, phase_tick);
        end
    endtask

    initial begin
        test_reset();
        test_phase_advance();
        test_full_cycle();
        test_pwm();
        test_pause();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
